adxl345_spi_responder: RTL and testbench

- Behavioural-synthesisable SPI responder that emulates the G-sensor end of the accelerometer 3-wire SPI link (SCLK, bidirectional SDAT, CS_N, INT).
- Used in simulation and hardware-in-loop builds in place of the physical sensor, so the Nios accelerometer SPI controller and game tilt logic can be driven with known X/Y/Z samples.
- Decodes the command byte (R/W, MB, 6-bit address), serves a small register file, and raises a data-ready interrupt.

---
 rtl/adxl345_pkg.sv | 36 +++
 rtl/adxl345_spi_responder_spi_input_sync.sv | 53 +++++
 rtl/adxl345_spi_responder.sv | 214 +++++++++++++++++++++
 tb/tb_adxl345_spi_responder.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adxl345_pkg.sv
// Shared constants for the ADXL345 SPI responder: register map,
// reset values, FSM state encoding and flag bit positions.
package adxl345_pkg;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAX1      = 6'h33;
    localparam logic [5:0] ADDR_DATAY0      = 6'h34;
    localparam logic [5:0] ADDR_DATAY1      = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    localparam logic [7:0] RST_BW_RATE     = 8'h0A;
    localparam logic [7:0] RST_POWER_CTL   = 8'h00;
    localparam logic [7:0] RST_INT_ENABLE  = 8'h00;
    localparam logic [7:0] RST_DATA_FORMAT = 8'h00;

    localparam int MEASURE_BIT    = 3;
    localparam int DATA_READY_BIT = 7;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CMD  = 2'd1;
    localparam state_t ST_RD   = 2'd2;
    localparam state_t ST_WR   = 2'd3;

    function automatic logic is_writable(input logic [5:0] a);
        return (a == ADDR_BW_RATE) || (a == ADDR_POWER_CTL) ||
               (a == ADDR_INT_ENABLE) || (a == ADDR_DATA_FORMAT);
    endfunction

endpackage

// File: rtl/adxl345_spi_responder_spi_input_sync.sv
// Synchronises the SPI pad inputs into clk domain and detects
// rising/falling edges of SCLK and CS_N on the synchronised copies.
module spi_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sclk,
    input  logic i_cs_n,
    input  logic i_sdat,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_cs_fall,
    output logic o_cs_rise,
    output logic o_sdat
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sdat_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;
    logic                   w_sclk;
    logic                   w_cs_n;

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n = r_cs_sync[SYNC_STAGES-1];

    // Shift chains plus one delayed copy for edge detection; idle-high reset
    // on SCLK and CS_N so leaving reset never looks like an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sclk_sync <= '1;
            r_cs_sync   <= '1;
            r_sdat_sync <= '0;
            r_sclk_prev <= 1'b1;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
            r_sdat_sync <= {r_sdat_sync[SYNC_STAGES-2:0], i_sdat};
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs_n;
        end
    end

    assign o_sclk_rise = w_sclk & ~r_sclk_prev;
    assign o_sclk_fall = ~w_sclk & r_sclk_prev;
    assign o_cs_fall   = ~w_cs_n & r_cs_prev;
    assign o_cs_rise   = w_cs_n & ~r_cs_prev;
    assign o_sdat      = r_sdat_sync[SYNC_STAGES-1];

endmodule

// File: rtl/adxl345_spi_responder.sv
// ADXL345 3-wire SPI slave emulation: command decode, small register
// file, coherent sample shadowing and a data-ready interrupt.
module adxl345_spi_responder
    import adxl345_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID       = 8'hE5
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        sclk_i,
    input  logic        cs_n_i,
    input  logic        sdat_i,
    output logic        sdat_o,
    output logic        sdat_oe,
    output logic        int_o,
    input  logic [15:0] accel_x,
    input  logic [15:0] accel_y,
    input  logic [15:0] accel_z,
    input  logic        sample_valid
);

    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_sdat;

    state_t     r_state;
    logic [2:0] r_bitcnt;
    logic [7:0] r_shift;
    logic [7:0] r_tx;
    logic [5:0] r_addr;
    logic       r_mb;
    logic       r_sdo;
    logic       r_oe;

    logic [7:0]  r_bw_rate;
    logic [7:0]  r_power_ctl;
    logic [7:0]  r_int_enable;
    logic [7:0]  r_data_format;
    logic [47:0] r_live;
    logic [47:0] r_shadow;
    logic        r_drdy;
    logic        r_int;

    logic [7:0] w_cmd;
    logic [5:0] w_next_addr;
    logic [5:0] w_rd_addr;
    logic [7:0] w_rd_data;
    logic       w_cs_start;
    logic       w_wr_en;
    logic       w_byte_rd_done;
    logic       w_drdy_set;
    logic       w_drdy_clr;

    spi_input_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk      (clk_clk),
        .i_rst      (reset_reset),
        .i_sclk     (sclk_i),
        .i_cs_n     (cs_n_i),
        .i_sdat     (sdat_i),
        .o_sclk_rise(w_sclk_rise),
        .o_sclk_fall(w_sclk_fall),
        .o_cs_fall  (w_cs_fall),
        .o_cs_rise  (w_cs_rise),
        .o_sdat     (w_sdat)
    );

    assign w_cmd       = {r_shift[6:0], w_sdat};
    assign w_next_addr = r_mb ? r_addr + 6'd1 : r_addr;
    assign w_cs_start  = (r_state == ST_IDLE) & w_cs_fall;

    assign w_wr_en = (r_state == ST_WR) & w_sclk_rise &
                     (r_bitcnt == 3'd7) & ~w_cs_rise;

    assign w_byte_rd_done = (r_state == ST_RD) & w_sclk_fall &
                            (r_bitcnt == 3'd7) & ~w_cs_rise;

    assign w_drdy_set = sample_valid & r_power_ctl[MEASURE_BIT];
    assign w_drdy_clr = w_byte_rd_done & (r_addr == ADDR_DATAZ1);

    // Read map: the byte loaded at command decode or at each byte boundary.
    always_comb begin
        w_rd_addr = (r_state == ST_CMD) ? w_cmd[5:0] : w_next_addr;
        case (w_rd_addr)
            ADDR_DEVID:       w_rd_data = DEVID;
            ADDR_BW_RATE:     w_rd_data = r_bw_rate;
            ADDR_POWER_CTL:   w_rd_data = r_power_ctl;
            ADDR_INT_ENABLE:  w_rd_data = r_int_enable;
            ADDR_DATA_FORMAT: w_rd_data = r_data_format;
            ADDR_DATAX0:      w_rd_data = r_shadow[7:0];
            ADDR_DATAX1:      w_rd_data = r_shadow[15:8];
            ADDR_DATAY0:      w_rd_data = r_shadow[23:16];
            ADDR_DATAY1:      w_rd_data = r_shadow[31:24];
            ADDR_DATAZ0:      w_rd_data = r_shadow[39:32];
            ADDR_DATAZ1:      w_rd_data = r_shadow[47:40];
            default:          w_rd_data = 8'h00;
        endcase
    end

    // Transaction FSM; a CS_N rise aborts whatever is in flight.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_tx     <= '0;
            r_addr   <= '0;
            r_mb     <= 1'b0;
            r_sdo    <= 1'b0;
            r_oe     <= 1'b0;
        end else if (w_cs_rise) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_oe     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_state  <= ST_CMD;
                        r_bitcnt <= '0;
                    end
                end
                ST_CMD: begin
                    if (w_sclk_rise) begin
                        r_shift  <= w_cmd;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_mb    <= w_cmd[6];
                            r_addr  <= w_cmd[5:0];
                            r_tx    <= w_rd_data;
                            r_state <= w_cmd[7] ? ST_RD : ST_WR;
                        end
                    end
                end
                ST_RD: begin
                    if (w_sclk_fall) begin
                        r_sdo    <= r_tx[7];
                        r_oe     <= 1'b1;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_addr <= w_next_addr;
                            r_tx   <= w_rd_data;
                        end else begin
                            r_tx <= {r_tx[6:0], 1'b0};
                        end
                    end
                end
                ST_WR: begin
                    if (w_sclk_rise) begin
                        r_shift  <= w_cmd;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_addr <= w_next_addr;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Writable configuration registers; other write targets are dropped.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_bw_rate     <= RST_BW_RATE;
            r_power_ctl   <= RST_POWER_CTL;
            r_int_enable  <= RST_INT_ENABLE;
            r_data_format <= RST_DATA_FORMAT;
        end else if (w_wr_en && is_writable(r_addr)) begin
            case (r_addr)
                ADDR_BW_RATE:     r_bw_rate     <= w_cmd;
                ADDR_POWER_CTL:   r_power_ctl   <= w_cmd;
                ADDR_INT_ENABLE:  r_int_enable  <= w_cmd;
                ADDR_DATA_FORMAT: r_data_format <= w_cmd;
                default:          r_bw_rate     <= r_bw_rate;
            endcase
        end
    end

    // Live samples follow sample_valid; shadow freezes them per transaction.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_live   <= '0;
            r_shadow <= '0;
        end else begin
            if (sample_valid) begin
                r_live <= {accel_z, accel_y, accel_x};
            end
            if (w_cs_start) begin
                r_shadow <= r_live;
            end
        end
    end

    // Data-ready flag (set beats clear) and its registered interrupt.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_drdy <= 1'b0;
            r_int  <= 1'b0;
        end else begin
            r_drdy <= w_drdy_set | (r_drdy & ~w_drdy_clr);
            r_int  <= r_drdy & r_int_enable[DATA_READY_BIT];
        end
    end

    assign sdat_o  = r_sdo;
    assign sdat_oe = r_oe;
    assign int_o   = r_int;

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Self-checking bench for adxl345_spi_responder: bit-banged SPI master
// against a byte-level register/sample model.
`timescale 1ns/1ps
module tb_adxl345_spi_responder;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b1;
    logic        cs_n = 1'b1;
    logic        sdi = 1'b0;
    logic        sv = 1'b0;
    logic [15:0] ax = '0;
    logic [15:0] ay = '0;
    logic [15:0] az = '0;
    logic        sdo;
    logic        oe;
    logic        irq;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    adxl345_spi_responder #(
        .SYNC_STAGES(2),
        .DEVID(8'hE5)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .sclk_i      (sclk),
        .cs_n_i      (cs_n),
        .sdat_i      (sdi),
        .sdat_o      (sdo),
        .sdat_oe     (oe),
        .int_o       (irq),
        .accel_x     (ax),
        .accel_y     (ay),
        .accel_z     (az),
        .sample_valid(sv)
    );

    // ---------------- reference model ----------------
    logic [7:0] m_bw, m_pc, m_ie, m_df;
    logic [7:0] m_live[6];
    logic [7:0] m_shadow[6];
    logic       m_drdy;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] wr_q[$];
    int         bad_oe;
    logic       oe_end;

    task automatic m_reset();
        m_bw = 8'h0A; m_pc = 8'h00; m_ie = 8'h00; m_df = 8'h00;
        for (int i = 0; i < 6; i++) begin
            m_live[i] = 8'h00;
            m_shadow[i] = 8'h00;
        end
        m_drdy = 1'b0;
    endtask

    function automatic logic [7:0] m_read(input logic [5:0] a);
        if (a == 6'h00) return 8'hE5;
        if (a == 6'h2C) return m_bw;
        if (a == 6'h2D) return m_pc;
        if (a == 6'h2E) return m_ie;
        if (a == 6'h31) return m_df;
        if (a >= 6'h32 && a <= 6'h37) return m_shadow[int'(a) - 50];
        return 8'h00;
    endfunction

    task automatic m_sample(input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] z);
        m_live[0] = x[7:0]; m_live[1] = x[15:8];
        m_live[2] = y[7:0]; m_live[3] = y[15:8];
        m_live[4] = z[7:0]; m_live[5] = z[15:8];
        if (m_pc[3]) m_drdy = 1'b1;
    endtask

    task automatic m_read_burst(input logic [5:0] a, input logic mb, input int n);
        logic [5:0] p;
        p = a;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(m_read(p));
            if (p == 6'h37) m_drdy = 1'b0;
            if (mb) p = p + 6'd1;
        end
    endtask

    task automatic m_write_burst(input logic [5:0] a, input logic mb);
        logic [5:0] p;
        p = a;
        foreach (wr_q[k]) begin
            case (p)
                6'h2C: m_bw = wr_q[k];
                6'h2D: m_pc = wr_q[k];
                6'h2E: m_ie = wr_q[k];
                6'h31: m_df = wr_q[k];
                default: ;
            endcase
            if (mb) p = p + 6'd1;
        end
    endtask

    // ---------------- SPI master drivers ----------------
    task automatic cs_start();
        @(negedge clk);
        cs_n = 1'b0;
        for (int i = 0; i < 6; i++) m_shadow[i] = m_live[i];
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_end(output logic oe_after);
        @(negedge clk);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        oe_after = oe;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic xfer_byte(input logic [7:0] tx, input int nbits,
                             input logic exp_oe, output logic [7:0] rx,
                             output int nbad);
        rx = '0;
        nbad = 0;
        for (int i = 7; i > 7 - nbits; i--) begin
            sclk = 1'b0;
            sdi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = sdo;
            if (oe !== exp_oe) nbad++;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic spi_read(input logic [5:0] a, input logic mb, input int n);
        logic [7:0] r;
        int b;
        got_q.delete();
        bad_oe = 0;
        cs_start();
        xfer_byte({1'b1, mb, a}, 8, 1'b0, r, b);
        bad_oe += b;
        for (int k = 0; k < n; k++) begin
            xfer_byte(8'h00, 8, 1'b1, r, b);
            bad_oe += b;
            got_q.push_back(r);
        end
        cs_end(oe_end);
    endtask

    task automatic spi_write(input logic [5:0] a, input logic mb);
        logic [7:0] r;
        int b;
        bad_oe = 0;
        cs_start();
        xfer_byte({1'b0, mb, a}, 8, 1'b0, r, b);
        bad_oe += b;
        foreach (wr_q[k]) begin
            xfer_byte(wr_q[k], 8, 1'b0, r, b);
            bad_oe += b;
        end
        cs_end(oe_end);
    endtask

    task automatic drive_sample(input logic [15:0] x, input logic [15:0] y,
                                input logic [15:0] z);
        @(negedge clk);
        ax = x; ay = y; az = z; sv = 1'b1;
        @(negedge clk);
        sv = 1'b0;
        m_sample(x, y, z);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (oe !== 1'b0) begin
            n_fail++; $display("FAIL reset sdat_oe: got %b want 0", oe);
        end
        n_checks++;
        if (sdo !== 1'b0) begin
            n_fail++; $display("FAIL reset sdat_o: got %b want 0", sdo);
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL reset int_o: got %b want 0", irq);
        end
        spi_read(6'h2C, 1'b1, 3);
        m_read_burst(6'h2C, 1'b1, 3);
        foreach (exp_q[k]) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL reset reg %0d: got %02h want %02h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_devid();
        spi_read(6'h00, 1'b0, 1);
        m_read_burst(6'h00, 1'b0, 1);
        n_checks++;
        if (got_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL devid: got %02h want %02h", got_q[0], exp_q[0]);
        end
        n_checks++;
        if (bad_oe !== 0) begin
            n_fail++; $display("FAIL devid oe window: got %0d bad bits want 0", bad_oe);
        end
        n_checks++;
        if (oe_end !== 1'b0) begin
            n_fail++; $display("FAIL devid oe drop: got %b want 0", oe_end);
        end
    endtask

    task automatic test_write_readback();
        logic [5:0] cfg[3];
        cfg[0] = 6'h2C; cfg[1] = 6'h2E; cfg[2] = 6'h31;
        wr_q = '{8'h08};
        spi_write(6'h2D, 1'b0);
        m_write_burst(6'h2D, 1'b0);
        spi_read(6'h2D, 1'b0, 1);
        m_read_burst(6'h2D, 1'b0, 1);
        n_checks++;
        if (got_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL power_ctl readback: got %02h want %02h", got_q[0], exp_q[0]);
        end
        wr_q = '{8'($urandom_range(1, 255))};
        spi_write(6'h10, 1'b0);
        m_write_burst(6'h10, 1'b0);
        spi_read(6'h10, 1'b0, 1);
        m_read_burst(6'h10, 1'b0, 1);
        n_checks++;
        if (got_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL unmapped write: got %02h want %02h", got_q[0], exp_q[0]);
        end
        for (int i = 0; i < 3; i++) begin
            wr_q = '{8'($urandom_range(0, 127))};
            spi_write(cfg[i], 1'b0);
            m_write_burst(cfg[i], 1'b0);
            spi_read(cfg[i], 1'b0, 1);
            m_read_burst(cfg[i], 1'b0, 1);
            n_checks++;
            if (got_q[0] !== exp_q[0]) begin
                n_fail++;
                $display("FAIL cfg readback %02h: got %02h want %02h", cfg[i], got_q[0], exp_q[0]);
            end
        end
    endtask

    task automatic test_burst();
        wr_q = '{8'h08, 8'h80};
        spi_write(6'h2D, 1'b1);
        m_write_burst(6'h2D, 1'b1);
        drive_sample(16'h1234, 16'hFFFE, 16'h0100);
        n_checks++;
        if (irq !== (m_drdy & m_ie[7])) begin
            n_fail++; $display("FAIL burst int set: got %b want %b", irq, m_drdy & m_ie[7]);
        end
        spi_read(6'h32, 1'b1, 6);
        m_read_burst(6'h32, 1'b1, 6);
        foreach (exp_q[k]) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL burst byte %0d: got %02h want %02h", k, got_q[k], exp_q[k]);
            end
        end
        n_checks++;
        if (irq !== (m_drdy & m_ie[7])) begin
            n_fail++; $display("FAIL burst int clear: got %b want %b", irq, m_drdy & m_ie[7]);
        end
    endtask

    task automatic test_coherence();
        logic [7:0] r;
        int b;
        drive_sample(16'($urandom_range(0, 65535) & 16'hAAAA),
                     16'($urandom), 16'($urandom));
        got_q.delete();
        cs_start();
        xfer_byte(8'hF2, 8, 1'b0, r, b);
        xfer_byte(8'h00, 8, 1'b1, r, b);
        got_q.push_back(r);
        drive_sample(16'h5555, 16'($urandom), 16'($urandom));
        for (int k = 1; k < 6; k++) begin
            xfer_byte(8'h00, 8, 1'b1, r, b);
            got_q.push_back(r);
        end
        cs_end(oe_end);
        m_read_burst(6'h32, 1'b1, 6);
        foreach (exp_q[k]) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL coherent byte %0d: got %02h want %02h", k, got_q[k], exp_q[k]);
            end
        end
        spi_read(6'h32, 1'b1, 2);
        m_read_burst(6'h32, 1'b1, 2);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL new sample byte %0d: got %02h want %02h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] r;
        int b;
        cs_start();
        xfer_byte(8'h2C, 8, 1'b0, r, b);
        xfer_byte(8'h5A, 5, 1'b0, r, b);
        cs_end(oe_end);
        n_checks++;
        if (oe_end !== 1'b0) begin
            n_fail++; $display("FAIL abort oe: got %b want 0", oe_end);
        end
        spi_read(6'h2C, 1'b0, 1);
        m_read_burst(6'h2C, 1'b0, 1);
        n_checks++;
        if (got_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL abort bw_rate: got %02h want %02h", got_q[0], exp_q[0]);
        end
        spi_read(6'h00, 1'b0, 1);
        m_read_burst(6'h00, 1'b0, 1);
        n_checks++;
        if (got_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL abort devid: got %02h want %02h", got_q[0], exp_q[0]);
        end
    endtask

    task automatic test_wrap();
        spi_read(6'h3F, 1'b1, 2);
        m_read_burst(6'h3F, 1'b1, 2);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL wrap byte %0d: got %02h want %02h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] pool[14];
        logic [5:0] a;
        logic       mb;
        int         n;
        int         op;
        pool = '{6'h00, 6'h2C, 6'h2D, 6'h2E, 6'h31, 6'h32, 6'h33,
                 6'h34, 6'h35, 6'h36, 6'h37, 6'h3F, 6'h10, 6'h30};
        for (int it = 0; it < 24; it++) begin
            op = $urandom_range(0, 2);
            a  = pool[$urandom_range(0, 13)];
            mb = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 3);
            if (op == 0) begin
                spi_read(a, mb, n);
                m_read_burst(a, mb, n);
                foreach (exp_q[k]) begin
                    n_checks++;
                    if (got_q[k] !== exp_q[k]) begin
                        n_fail++;
                        $display("FAIL rand read a=%02h b%0d: got %02h want %02h",
                                 a, k, got_q[k], exp_q[k]);
                    end
                end
            end else if (op == 1) begin
                wr_q.delete();
                for (int k = 0; k < n; k++) wr_q.push_back(8'($urandom));
                spi_write(a, mb);
                m_write_burst(a, mb);
            end else begin
                drive_sample(16'($urandom), 16'($urandom), 16'($urandom));
            end
            n_checks++;
            if (irq !== (m_drdy & m_ie[7])) begin
                n_fail++;
                $display("FAIL rand int_o it%0d: got %b want %b", it, irq, m_drdy & m_ie[7]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        int b;
        wr_q = '{8'h55, 8'h08, 8'h80};
        spi_write(6'h2C, 1'b1);
        m_write_burst(6'h2C, 1'b1);
        drive_sample(16'($urandom), 16'($urandom), 16'($urandom));
        cs_start();
        xfer_byte(8'h80, 8, 1'b0, r, b);
        xfer_byte(8'h00, 3, 1'b1, r, b);
        n_checks++;
        if (oe !== 1'b1) begin
            n_fail++; $display("FAIL pre-reset oe: got %b want 1", oe);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (oe !== 1'b0) begin
            n_fail++; $display("FAIL reset mid-read oe: got %b want 0", oe);
        end
        cs_n = 1'b1;
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        m_reset();
        repeat (4) @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL reset mid int_o: got %b want 0", irq);
        end
        spi_read(6'h2C, 1'b1, 3);
        m_read_burst(6'h2C, 1'b1, 3);
        foreach (exp_q[k]) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL post-reset reg %0d: got %02h want %02h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_devid();
        test_write_readback();
        test_burst();
        test_coherence();
        test_abort();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
